// File: rtl/bit_packer_pkg.sv
// Shared types and constants for the bit_packer block (state encoding, counter width, default word size).
package bit_packer_pkg;
  localparam int BIT_PACKER_COUNT_W   = 16;
  localparam int BIT_PACKER_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_PARITY  = 2'd1,
    ST_HOLD    = 2'd2
  } bp_state_e;
endpackage

// File: rtl/bit_packer_shreg.sv
// LSB-first word assembly register: writes one bit per strobe at idx and flags
// the write that completes the word.
module bit_packer_shreg
  import bit_packer_pkg::*;
#(
  parameter int WIDTH = BIT_PACKER_DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       bit_in,
  input  logic                       clr,
  output logic [WIDTH-1:0]           shreg,
  output logic [$clog2(WIDTH)-1:0]   idx,
  output logic                       done
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d, idx_eff;

  // clr restarts the word; a write in the same cycle lands at bit 0
  always_comb begin
    idx_eff = clr ? '0 : idx_q;
    done    = wr_en && (idx_eff == IW'(WIDTH-1));
    shreg_d = shreg_q;
    idx_d   = idx_eff;
    if (wr_en) begin
      shreg_d[idx_eff] = bit_in;
      idx_d            = done ? '0 : idx_eff + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign shreg = shreg_q;
  assign idx   = idx_q;
endmodule

// File: rtl/bit_packer.sv
// Drains a 1-bit FIFO into WIDTH-bit words and offers them on an ENA/RDY get port.
// Optional trailing even-parity bit per word when BIT_PACKER_PARITY_EN is defined.
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int WIDTH = BIT_PACKER_DEF_WIDTH
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          in_first,
  input  logic                          in_first__RDY,
  input  logic                          in_deq__RDY,
  output logic                          in_deq__ENA,
  input  logic                          get__ENA,
  output logic                          get__RDY,
  output logic [WIDTH-1:0]              get,
  output logic                          get_perr,
  output logic [BIT_PACKER_COUNT_W-1:0] count
);
  bp_state_e                     state_q, state_d;
  logic [BIT_PACKER_COUNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]              shreg;
  logic [$clog2(WIDTH)-1:0]      idx;
  logic                          done;
  logic                          deq_ok, deq, wr_en, clr;

  assign deq_ok = in_deq__RDY & in_first__RDY;
  // In HOLD a dequeue only happens alongside the word being taken
  assign deq    = (state_q == ST_HOLD) ? (get__ENA & deq_ok) : deq_ok;
  assign wr_en  = deq & (state_q != ST_PARITY);
  assign clr    = (state_q == ST_HOLD);

  bit_packer_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk    (CLK),
    .rst_n  (nRST),
    .wr_en  (wr_en),
    .bit_in (in_first),
    .clr    (clr),
    .shreg  (shreg),
    .idx    (idx),
    .done   (done)
  );

`ifdef BIT_PACKER_PARITY_EN
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    get__RDY = 1'b0;
`ifdef BIT_PACKER_PARITY_EN
    perr_d   = perr_q;
`endif
    case (state_q)
      ST_COLLECT: begin
        if (done) begin
`ifdef BIT_PACKER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_HOLD;
`endif
        end
      end
`ifdef BIT_PACKER_PARITY_EN
      ST_PARITY: begin
        if (deq) begin
          perr_d  = (^shreg) ^ in_first;
          state_d = ST_HOLD;
        end
      end
`endif
      ST_HOLD: begin
        get__RDY = 1'b1;
        if (get__ENA) begin
          count_d = count_q + 1'b1;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_COLLECT;
      count_q <= '0;
`ifdef BIT_PACKER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
`ifdef BIT_PACKER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign in_deq__ENA = deq & nRST;
  assign get         = shreg;
  assign count       = count_q;
`ifdef BIT_PACKER_PARITY_EN
  assign get_perr    = perr_q;
`else
  assign get_perr    = 1'b0;
`endif
endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer (WIDTH=8): reset, words, parity, backpressure/overlap, stall, count wrap.
module tb_bit_packer;
  logic        CLK, nRST;
  logic        in_first, in_first__RDY, in_deq__RDY, in_deq__ENA;
  logic        get__ENA, get__RDY, get_perr;
  logic [7:0]  get;
  logic [15:0] count;
  int          errors = 0;
  int          checks = 0;

  bit_packer #(.WIDTH(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_first(in_first), .in_first__RDY(in_first__RDY),
    .in_deq__RDY(in_deq__RDY), .in_deq__ENA(in_deq__ENA),
    .get__ENA(get__ENA), .get__RDY(get__RDY),
    .get(get), .get_perr(get_perr), .count(count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_first      = w[i];
      in_first__RDY = 1'b1;
      in_deq__RDY   = 1'b1;
      @(negedge CLK);
    end
    in_first__RDY = 1'b0;
  endtask

  task automatic send_par(input logic p);
`ifdef BIT_PACKER_PARITY_EN
    in_first      = p;
    in_first__RDY = 1'b1;
    in_deq__RDY   = 1'b1;
    @(negedge CLK);
    in_first__RDY = 1'b0;
`else
    if (p) in_first = 1'b0;
`endif
  endtask

  task automatic accept();
    in_first__RDY = 1'b0;
    get__ENA      = 1'b1;
    @(negedge CLK);
    get__ENA      = 1'b0;
  endtask

  logic exp_perr;

  initial begin
    nRST = 1'b0; in_first = 1'b1; in_first__RDY = 1'b1; in_deq__RDY = 1'b1; get__ENA = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_deq_ena", in_deq__ENA, 0);
    chk("rst_get_rdy", get__RDY, 0);
    chk("rst_count",   count, 0);
    chk("rst_get",     get, 0);
    chk("rst_perr",    get_perr, 0);
    in_first__RDY = 1'b0;
    nRST = 1'b1;
    // get__ENA without a word present is ignored
    get__ENA = 1'b1;
    @(negedge CLK);
    get__ENA = 1'b0;
    chk("ena_no_rdy_count", count, 0);

    // Mid-cycle reset during a partial word
    send_bits(8'hFF, 0, 2);
    in_first = 1'b1; in_first__RDY = 1'b1; in_deq__RDY = 1'b1;
    #2 nRST = 1'b0;
    #1 chk("midrst_deq_ena", in_deq__ENA, 0);
    chk("midrst_get_rdy", get__RDY, 0);
    chk("midrst_count",   count, 0);
    chk("midrst_idx",     dut.u_shreg.idx_q, 0);
    in_first__RDY = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // Basic word 0xA5
    send_bits(8'hA5, 0, 7);
    send_par(1'b0);
    chk("a5_rdy",  get__RDY, 1);
    chk("a5_get",  get, 8'hA5);
    chk("a5_perr", get_perr, 0);

    // Backpressure: word held, no dequeue
    get__ENA = 1'b0; in_first = 1'b0; in_first__RDY = 1'b1; in_deq__RDY = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_no_deq", in_deq__ENA, 0);
    end
    chk("bp_get_stable", get, 8'hA5);
    chk("bp_rdy",        get__RDY, 1);

    // Overlap: take word and dequeue bit 0 of next word (0x3B) together
    in_first = 1'b1; get__ENA = 1'b1;
    #1 chk("ovl_deq_ena", in_deq__ENA, 1);
    @(negedge CLK);
    get__ENA = 1'b0; in_first__RDY = 1'b0;
    chk("ovl_count", count, 1);
    chk("ovl_idx",   dut.u_shreg.idx_q, 1);
    chk("ovl_rdy",   get__RDY, 0);

    // Stall after bits 1..3
    send_bits(8'h3B, 1, 3);
    in_first = 1'b1; in_first__RDY = 1'b1; in_deq__RDY = 1'b0;
    repeat (10) @(negedge CLK);
    #1 chk("stall_deq_ena", in_deq__ENA, 0);
    chk("stall_idx", dut.u_shreg.idx_q, 4);
    send_bits(8'h3B, 4, 7);
    send_par(1'b1);
    chk("stall_rdy",  get__RDY, 1);
    chk("stall_get",  get, 8'h3B);
    chk("stall_perr", get_perr, 0);
    accept();
    chk("stall_count", count, 2);

    // Parity error word: 0xA5 with parity bit 1
    send_bits(8'hA5, 0, 7);
    send_par(1'b1);
`ifdef BIT_PACKER_PARITY_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    chk("perr_get",  get, 8'hA5);
    chk("perr_flag", get_perr, exp_perr);
    accept();
    chk("perr_count", count, 3);

    // Count wrap: preload near the top instead of delivering 65534 words
    force dut.count_q = 16'hFFFE;
    @(negedge CLK);
    release dut.count_q;
    @(negedge CLK);
    chk("wrap_preload", count, 16'hFFFE);
    send_bits(8'h01, 0, 7); send_par(1'b1); accept();
    chk("wrap_ffff", count, 16'hFFFF);
    send_bits(8'h02, 0, 7); send_par(1'b1); accept();
    chk("wrap_zero", count, 16'h0000);
    send_bits(8'h80, 0, 7); send_par(1'b1);
    chk("wrap_get", get, 8'h80);
    accept();
    chk("wrap_one", count, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
